// File: rtl/hex_display_ctrl.sv
// ============================================================================
// Module  : hex_display_ctrl
// Brief   : Collects a serial decoded-bit stream, latches the last frame as
//           hex nibbles with optional leading-zero blanking, then holds it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_display_ctrl #(
  parameter int NUM_DIGITS  = 6,
  parameter int SIZE_DATA   = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_bit_valid,
  input  logic                                         i_bit,
  input  logic                                         i_frame_end,
  input  logic                                         i_blank_lz,
  output logic                                         o_ready,
  output logic [NUM_DIGITS*SIZE_DATA-1:0]              o_data,
  output logic [NUM_DIGITS-1:0]                        o_en_hex,
  output logic [$clog2(NUM_DIGITS*SIZE_DATA+1)-1:0]    o_bit_cnt,
  output logic                                         o_overflow
);

  localparam int W   = NUM_DIGITS * SIZE_DATA;
  localparam int BCW = $clog2(W + 1);

  localparam logic [BCW-1:0]   C_W_CNT     = BCW'(W);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        shreg_q, shreg_d;
  logic [BCW-1:0]      cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [W-1:0]        data_q, data_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                ovf_out_q, ovf_out_d;
  logic [CNT_W-1:0]    hold_q, hold_d;

  logic                  w_accept;
  logic                  w_full;
  logic [W-1:0]          w_shift;
  logic [NUM_DIGITS-1:0] w_en_blank;
  logic                  w_nz_seen;

  assign o_ready  = (state_q != HOLD);
  assign w_accept = i_bit_valid && o_ready;
  assign w_full   = (cnt_q == C_W_CNT);
  assign w_shift  = {shreg_q[W-2:0], i_bit};

  // Scan from the most significant digit down: once a nonzero digit is seen,
  // every lower digit stays lit. Digit 0 is always lit.
  always_comb begin
    w_en_blank = '0;
    w_nz_seen  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_nz_seen     = w_nz_seen | (|w_shift[k*SIZE_DATA +: SIZE_DATA]);
      w_en_blank[k] = w_nz_seen || (k == 0);
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    en_d      = en_q;
    ovf_out_d = ovf_out_q;
    hold_d    = hold_q;

    case (state_q)
      IDLE, COLLECT: begin
        if (w_accept) begin
          if (i_frame_end) begin
            data_d    = w_shift;
            ovf_out_d = ovf_q | w_full;
            en_d      = i_blank_lz ? w_en_blank : {NUM_DIGITS{1'b1}};
            shreg_d   = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            hold_d    = '0;
            state_d   = HOLD;
          end else begin
            shreg_d = w_shift;
            if (w_full) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
            state_d = COLLECT;
          end
        end
      end

      HOLD: begin
        if (hold_q == C_HOLD_LAST) begin
          hold_d  = '0;
          state_d = COLLECT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      en_q      <= '0;
      ovf_out_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      en_q      <= en_d;
      ovf_out_q <= ovf_out_d;
      hold_q    <= hold_d;
    end
  end

  assign o_data     = data_q;
  assign o_en_hex   = en_q;
  assign o_bit_cnt  = cnt_q;
  assign o_overflow = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// ============================================================================
// Module  : tb_hex_display_ctrl
// Brief   : Directed bench for hex_display_ctrl with a reference model and a
//           queue of expected latch results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_ctrl;

  localparam int ND   = 2;
  localparam int SD   = 4;
  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       bit_valid;
  logic       bit_in;
  logic       frame_end;
  logic       blank_lz;
  logic       ready;
  logic [7:0] data;
  logic [1:0] en_hex;
  logic [3:0] bit_cnt;
  logic       overflow;

  hex_display_ctrl #(
    .NUM_DIGITS (ND),
    .SIZE_DATA  (SD),
    .HOLD_CYCLES(HOLD),
    .CNT_W      (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_bit_valid(bit_valid),
    .i_bit      (bit_in),
    .i_frame_end(frame_end),
    .i_blank_lz (blank_lz),
    .o_ready    (ready),
    .o_data     (data),
    .o_en_hex   (en_hex),
    .o_bit_cnt  (bit_cnt),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_sh;
  int          m_cnt;
  logic        m_ovf;
  int          m_hold;
  logic [10:0] m_disp;   // {overflow, en[1:0], data[7:0]}
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("ready",    32'(ready),    32'(m_hold == 0));
    chk("bit_cnt",  32'(bit_cnt),  32'(m_cnt));
    chk("data",     32'(data),     32'(m_disp[7:0]));
    chk("en_hex",   32'(en_hex),   32'(m_disp[9:8]));
    chk("overflow", 32'(overflow), 32'(m_disp[10]));
  endtask

  // One clock cycle of stimulus followed by a model update and checks.
  task automatic step(input logic v, input logic b, input logic fe);
    logic       acc;
    logic       latched;
    logic [7:0] sh_n;
    logic [1:0] en_n;
    logic       ovf_n;
    logic [10:0] exp;
    bit_valid = v;
    bit_in    = b;
    frame_end = fe;
    acc       = v && (m_hold == 0);
    @(posedge clk);
    latched = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (acc) begin
      sh_n = {m_sh[6:0], b};
      if (fe) begin
        ovf_n = m_ovf | (m_cnt == 8);
        en_n  = blank_lz ? {(|sh_n[7:4]), 1'b1} : 2'b11;
        exp_q.push_back({ovf_n, en_n, sh_n});
        m_disp  = {ovf_n, en_n, sh_n};
        m_sh    = '0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_hold  = HOLD;
        latched = 1'b1;
      end else begin
        if (m_cnt == 8) m_ovf = 1'b1;
        else            m_cnt++;
        m_sh = sh_n;
      end
    end
    #1;
    if (latched) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        chk("latch_data", 32'(data),     32'(exp[7:0]));
        chk("latch_en",   32'(en_hex),   32'(exp[9:8]));
        chk("latch_ovf",  32'(overflow), 32'(exp[10]));
      end
    end
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    bit_valid = 1'b0;
    frame_end = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_sh   = '0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_hold = 0;
    m_disp = '0;
    exp_q.delete();
    check_state();
  endtask

  // Send n bits MSB-first from 'bits', frame_end on the last one.
  task automatic send_frame(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], (i == 0));
    end
    bit_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic wait_hold();
    int guard = 0;
    while (m_hold > 0 && guard < 20) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  initial begin
    int low;
    logic t;
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_end = 1'b0; blank_lz = 1'b0;
    m_sh = '0; m_cnt = 0; m_ovf = 1'b0; m_hold = 0; m_disp = '0;

    // 1. reset
    do_reset(2);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ready", 32'(ready), 32'd1);

    // 2. A5, no blanking; hold length measured on the DUT directly
    blank_lz = 1'b0;
    send_frame(16'h00A5, 8);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_en", 32'(en_hex), 32'h3);
    low = 1;
    while (ready !== 1'b1 && low < 20) begin
      step(1'b0, 1'b0, 1'b0);
      if (ready !== 1'b1) low++;
    end
    chk("hold_len", 32'(low), 32'(HOLD));

    // 3. leading-zero blanking
    blank_lz = 1'b1;
    send_frame(16'h0007, 4);
    chk("b07_data", 32'(data), 32'h07);
    chk("b07_en", 32'(en_hex), 32'h1);
    wait_hold();
    send_frame(16'h0000, 8);
    chk("b00_en", 32'(en_hex), 32'h1);
    wait_hold();
    send_frame(16'h0031, 8);
    chk("b31_en", 32'(en_hex), 32'h3);
    wait_hold();

    // 4. overflow: 10 bits, counter saturates, only last 8 kept
    blank_lz = 1'b0;
    for (int i = 9; i >= 2; i--) step(1'b1, 1'(10'b1100001111 >> i), 1'b0);
    chk("sat_cnt8", 32'(bit_cnt), 32'd8);
    step(1'b1, 1'b1, 1'b0);
    chk("sat_cnt9", 32'(bit_cnt), 32'd8);
    step(1'b1, 1'b1, 1'b1);
    bit_valid = 1'b0; frame_end = 1'b0;
    chk("ovf_data", 32'(data), 32'h0F);
    chk("ovf_flag", 32'(overflow), 32'd1);
    wait_hold();
    send_frame(16'h005A, 8);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // 5. valid held with toggling bits during HOLD
    t = 1'b0;
    while (m_hold > 0) begin
      step(1'b1, t, 1'b0);
      t = ~t;
    end
    step(1'b1, 1'b1, 1'b0);
    chk("restart_cnt", 32'(bit_cnt), 32'd1);
    for (int i = 6; i >= 0; i--) step(1'b1, 1'(7'b0010011 >> i), (i == 0));
    bit_valid = 1'b0; frame_end = 1'b0;
    chk("restart_data", 32'(data), 32'h93);
    wait_hold();

    // 6. reset mid-frame, then reset mid-hold
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset(1);
    send_frame(16'h003C, 8);
    chk("post_rst_data", 32'(data), 32'h3C);
    step(1'b0, 1'b0, 1'b0);
    do_reset(1);
    chk("hold_rst_data", 32'(data), 32'h00);
    chk("hold_rst_en", 32'(en_hex), 32'h0);
    chk("hold_rst_ready", 32'(ready), 32'd1);
    send_frame(16'h0001, 1);
    chk("idle_latch_data", 32'(data), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
